fetch_if_id_stage: RTL and testbench

// - Instruction fetch stage plus IF/ID pipeline register. Feeds the decode/RF stage.
// - Owns the PC and issues instruction-memory requests over a req/ack handshake.
// - Consumes the hazard detection unit's stall signal (hold PC and IF/ID) and the EX-stage branch redirect.

---
 rtl/fetch_pkg.sv | 38 +++
 rtl/fetch_if_id_stage_if_id_reg.sv | 39 +++
 rtl/fetch_if_id_stage.sv | 196 +++++++++++++++++++
 tb/tb_fetch_if_id_stage.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch stage
//               and its IF/ID pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    // Architectural no-op used to fill an empty IF/ID slot (mov r0,r0).
    localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;

    // Sequential fetch increment in bytes.
    localparam int unsigned PC_STEP = 4;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        REQ   = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Contents of the IF/ID pipeline register.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } if_id_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_if_id_stage_if_id_reg.sv
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register. Flush wins over load and leaves the
//               slot holding an invalid no-op at address zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_reg
    import fetch_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_load,
    input  logic   i_flush,
    input  if_id_t i_d,
    output if_id_t o_q
);

    localparam if_id_t C_EMPTY = '{instr: NOP_INSTR, pc: 32'h0, valid: 1'b0};

    if_id_t r_q;

    // Register update: reset and flush both empty the slot, load captures d.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= C_EMPTY;
        end else if (i_flush) begin
            r_q <= C_EMPTY;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/fetch_if_id_stage.sv
// ============================================================================
// Module      : fetch_if_id_stage
// Description : Instruction fetch stage with PC, req/ack instruction-memory
//               sequencer, single-entry hold buffer for stalls, branch
//               redirect with in-flight request draining, and the IF/ID
//               pipeline register feeding decode.
// Options     : FETCH_PERF_CNT_EN - adds saturating fetch/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_if_id_stage
    import fetch_pkg::*;
#(
    // The IF/ID struct carries 32-bit fields, so these stay at 32.
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_in,
    input  logic               branch_taken_in,
    input  logic [ADDR_W-1:0]  branch_target_in,
    output logic               imem_req_out,
    output logic [ADDR_W-1:0]  imem_addr_out,
    input  logic               imem_ack_in,
    input  logic [INSTR_W-1:0] imem_rdata_in,
    output logic [INSTR_W-1:0] if_id_instr_out,
    output logic [ADDR_W-1:0]  if_id_pc_out,
    output logic               if_id_valid_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetch_cnt_out,
    output logic [31:0]        perf_stall_cnt_out
`endif
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    fetch_state_t       r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_buf_instr;
    logic [ADDR_W-1:0]  r_buf_pc;
    logic               r_kill;
    // Low for the first cycle after reset so no request overlaps reset.
    logic               r_req_en;

    logic               w_load;
    logic               w_flush;
    if_id_t             w_d;
    if_id_t             w_if_id;

    // ------------------------------------------------------------------
    // Memory request: only the REQ state drives a request.
    // ------------------------------------------------------------------
    assign imem_req_out  = r_req_en && (r_state == REQ);
    assign imem_addr_out = r_pc;

    // IF/ID control derived from the current state and handshake inputs.
    always_comb begin
        w_load  = 1'b0;
        w_flush = 1'b0;
        w_d     = '{instr: imem_rdata_in, pc: r_pc, valid: 1'b1};
        if (r_req_en) begin
            case (r_state)
                REQ: begin
                    if (branch_taken_in) begin
                        w_flush = 1'b1;
                    end else if (imem_ack_in && !stall_in) begin
                        w_load = 1'b1;
                    end else if (!imem_ack_in && !stall_in) begin
                        // Nothing arrived and decode can accept: bubble.
                        w_flush = 1'b1;
                    end
                end
                HOLD: begin
                    if (branch_taken_in) begin
                        w_flush = 1'b1;
                    end else if (!stall_in) begin
                        w_load = 1'b1;
                        w_d    = '{instr: r_buf_instr, pc: r_buf_pc, valid: 1'b1};
                    end
                end
                default: begin
                    // DRAIN: IF/ID was already flushed on entry.
                end
            endcase
        end
    end

    // Fetch sequencer, PC and hold buffer; branch redirect overrides stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= REQ;
            r_pc        <= RESET_PC;
            r_buf_instr <= NOP_INSTR;
            r_buf_pc    <= '0;
            r_kill      <= 1'b0;
            r_req_en    <= 1'b0;
        end else begin
            r_req_en <= 1'b1;
            if (r_req_en) begin
                case (r_state)
                    REQ: begin
                        if (branch_taken_in) begin
                            r_pc <= branch_target_in;
                            if (!imem_ack_in) begin
                                // Request still outstanding: finish it
                                // without letting its data through.
                                r_kill  <= 1'b1;
                                r_state <= DRAIN;
                            end
                        end else if (imem_ack_in) begin
                            if (!stall_in) begin
                                r_pc <= r_pc + ADDR_W'(PC_STEP);
                            end else begin
                                r_buf_instr <= imem_rdata_in;
                                r_buf_pc    <= r_pc;
                                r_state     <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (branch_taken_in) begin
                            r_pc    <= branch_target_in;
                            r_state <= REQ;
                        end else if (!stall_in) begin
                            // r_pc still addresses the buffered word.
                            r_pc    <= r_pc + ADDR_W'(PC_STEP);
                            r_state <= REQ;
                        end
                    end
                    DRAIN: begin
                        if (branch_taken_in) begin
                            r_pc <= branch_target_in;
                        end
                        if (imem_ack_in && r_kill) begin
                            r_kill  <= 1'b0;
                            r_state <= REQ;
                        end
                    end
                    default: begin
                        r_state <= REQ;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // IF/ID register
    // ------------------------------------------------------------------
    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_d     (w_d),
        .o_q     (w_if_id)
    );

    assign if_id_instr_out = w_if_id.instr;
    assign if_id_pc_out    = w_if_id.pc;
    assign if_id_valid_out = w_if_id.valid;

`ifdef FETCH_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    logic [31:0] r_perf_fetch_cnt;
    logic [31:0] r_perf_stall_cnt;

    // Saturating counts of valid IF/ID writes and stalled cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetch_cnt <= '0;
            r_perf_stall_cnt <= '0;
        end else begin
            if (w_load && !w_flush) begin
                r_perf_fetch_cnt <= sat_inc(r_perf_fetch_cnt);
            end
            if (stall_in) begin
                r_perf_stall_cnt <= sat_inc(r_perf_stall_cnt);
            end
        end
    end

    assign perf_fetch_cnt_out = r_perf_fetch_cnt;
    assign perf_stall_cnt_out = r_perf_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_if_id_stage.sv
// ============================================================================
// Module      : tb_fetch_if_id_stage
// Description : Directed scoreboard bench for fetch_if_id_stage. Expected
//               IF/ID contents are queued by the stimulus; a monitor pops
//               and compares whenever a new valid instruction appears.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_if_id_stage;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_in;
    logic        branch_taken_in;
    logic [31:0] branch_target_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ack_in;
    logic [31:0] imem_rdata_in;
    logic [31:0] if_id_instr_out;
    logic [31:0] if_id_pc_out;
    logic        if_id_valid_out;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt_out;
    logic [31:0] perf_stall_cnt_out;
`endif

    logic        ack_en;
    logic        force_en;
    logic [31:0] force_val;

    int n_tests = 0;
    int n_fail  = 0;

    if_id_t exp_q[$];

    always #5 clk = ~clk;

    // Instruction memory contents as a function of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8) return 32'hE3A0_1005;
        return 32'hE000_0000 | {16'h0, a[15:0]};
    endfunction

    assign imem_ack_in   = ack_en;
    assign imem_rdata_in = force_en ? force_val : mem_word(imem_addr_out);

    fetch_if_id_stage dut (
        .clk              (clk),
        .reset            (reset),
        .stall_in         (stall_in),
        .branch_taken_in  (branch_taken_in),
        .branch_target_in (branch_target_in),
        .imem_req_out     (imem_req_out),
        .imem_addr_out    (imem_addr_out),
        .imem_ack_in      (imem_ack_in),
        .imem_rdata_in    (imem_rdata_in),
        .if_id_instr_out  (if_id_instr_out),
        .if_id_pc_out     (if_id_pc_out),
        .if_id_valid_out  (if_id_valid_out)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt_out (perf_fetch_cnt_out),
        .perf_stall_cnt_out (perf_stall_cnt_out)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        exp_q.push_back('{instr: mem_word(pc), pc: pc, valid: 1'b1});
    endtask

    // Monitor: a new valid IF/ID value is compared against the queue head.
    initial begin
        logic        seen_valid;
        logic [31:0] seen_instr;
        logic [31:0] seen_pc;
        if_id_t      e;
        seen_valid = 1'b0;
        seen_instr = '0;
        seen_pc    = '0;
        forever begin
            @(negedge clk);
            if (if_id_valid_out === 1'b1 &&
                (!seen_valid || if_id_instr_out !== seen_instr || if_id_pc_out !== seen_pc)) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL if_id_unexpected: got instr=%h pc=%h, expected no new instruction",
                             if_id_instr_out, if_id_pc_out);
                end else begin
                    e = exp_q.pop_front();
                    if (if_id_instr_out !== e.instr || if_id_pc_out !== e.pc) begin
                        n_fail++;
                        $display("FAIL if_id_data: got instr=%h pc=%h, expected instr=%h pc=%h",
                                 if_id_instr_out, if_id_pc_out, e.instr, e.pc);
                    end
                end
            end
            seen_valid = (if_id_valid_out === 1'b1);
            seen_instr = if_id_instr_out;
            seen_pc    = if_id_pc_out;
        end
    end

    // Directed stimulus.
    initial begin
        reset            = 1'b1;
        stall_in         = 1'b0;
        branch_taken_in  = 1'b0;
        branch_target_in = '0;
        ack_en           = 1'b0;
        force_en         = 1'b0;
        force_val        = '0;
        repeat (3) tick();

        // Reset values.
        chk("rst_valid", {31'h0, if_id_valid_out}, 32'h0);
        chk("rst_instr", if_id_instr_out, NOP_INSTR);
        chk("rst_pc",    if_id_pc_out, 32'h0);
        chk("rst_req",   {31'h0, imem_req_out}, 32'h0);

        // Streaming fetch with ack tied high.
        reset  = 1'b0;
        ack_en = 1'b1;
        chk("req_low_at_release", {31'h0, imem_req_out}, 32'h0);
        tick();
        chk("first_req",  {31'h0, imem_req_out}, 32'h1);
        chk("first_addr", imem_addr_out, 32'h0);
        push(32'h0);
        tick();
        push(32'h4);
        tick();
        chk("addr_8", imem_addr_out, 32'h8);

        // Stall for three cycles while the word at 0x8 is acked.
        stall_in = 1'b1;
        tick();
        chk("hold_req", {31'h0, imem_req_out}, 32'h0);
        chk("hold_ifid_pc", if_id_pc_out, 32'h4);
        tick();
        tick();
        chk("hold_ifid_pc_late", if_id_pc_out, 32'h4);
        chk("hold_ifid_valid", {31'h0, if_id_valid_out}, 32'h1);
        stall_in = 1'b0;
        push(32'h8);
        tick();
        chk("post_hold_addr", imem_addr_out, 32'hC);

        // Enter HOLD again, then branch to 0x100 while stalled.
        stall_in = 1'b1;
        tick();
        chk("hold2_req", {31'h0, imem_req_out}, 32'h0);
        branch_taken_in  = 1'b1;
        branch_target_in = 32'h100;
        tick();
        branch_taken_in = 1'b0;
        stall_in        = 1'b0;
        chk("br_valid", {31'h0, if_id_valid_out}, 32'h0);
        chk("br_instr", if_id_instr_out, NOP_INSTR);
        chk("br_req",   {31'h0, imem_req_out}, 32'h1);
        chk("br_addr",  imem_addr_out, 32'h100);
        push(32'h100);
        tick();

        // Redirect to 0x40 on an acked cycle, then let 0x40 stall on ack.
        branch_taken_in  = 1'b1;
        branch_target_in = 32'h40;
        tick();
        branch_taken_in = 1'b0;
        ack_en          = 1'b0;
        chk("addr_40", imem_addr_out, 32'h40);
        chk("redirect_valid", {31'h0, if_id_valid_out}, 32'h0);
        tick();
        chk("addr_40_stable", imem_addr_out, 32'h40);
        chk("req_40_pending", {31'h0, imem_req_out}, 32'h1);

        // Branch to 0x200 with 0x40 outstanding: must drain.
        branch_taken_in  = 1'b1;
        branch_target_in = 32'h200;
        tick();
        branch_taken_in = 1'b0;
        chk("drain_req", {31'h0, imem_req_out}, 32'h0);
        tick();
        chk("drain_req_wait", {31'h0, imem_req_out}, 32'h0);
        ack_en    = 1'b1;
        force_en  = 1'b1;
        force_val = mem_word(32'h40);
        tick();
        force_en = 1'b0;
        chk("drain_valid", {31'h0, if_id_valid_out}, 32'h0);
        chk("drain_exit_req",  {31'h0, imem_req_out}, 32'h1);
        chk("drain_exit_addr", imem_addr_out, 32'h200);
        push(32'h200);
        tick();

        // Reset while an instruction sits in the hold buffer.
        stall_in = 1'b1;
        tick();
        chk("hold3_req", {31'h0, imem_req_out}, 32'h0);
        reset    = 1'b1;
        stall_in = 1'b0;
        tick();
        chk("rst2_valid", {31'h0, if_id_valid_out}, 32'h0);
        chk("rst2_instr", if_id_instr_out, NOP_INSTR);
        chk("rst2_pc",    if_id_pc_out, 32'h0);
        chk("rst2_req",   {31'h0, imem_req_out}, 32'h0);
        chk("rst2_addr",  imem_addr_out, 32'h0);
        reset = 1'b0;
        tick();
        chk("rst2_first_req",  {31'h0, imem_req_out}, 32'h1);
        chk("rst2_first_addr", imem_addr_out, 32'h0);
        push(32'h0);
        tick();

        // PC wraps modulo 2^32.
        branch_taken_in  = 1'b1;
        branch_target_in = 32'hFFFF_FFFC;
        tick();
        branch_taken_in = 1'b0;
        chk("top_addr", imem_addr_out, 32'hFFFF_FFFC);
        push(32'hFFFF_FFFC);
        tick();
        chk("wrap_addr", imem_addr_out, 32'h0);
        push(32'h0);
        tick();

        // No ack and no stall gives a bubble.
        ack_en = 1'b0;
        tick();
        chk("bubble_valid", {31'h0, if_id_valid_out}, 32'h0);
        chk("bubble_instr", if_id_instr_out, NOP_INSTR);

`ifdef FETCH_PERF_CNT_EN
        // Ten fetches followed by four stalled cycles.
        reset = 1'b1;
        tick();
        chk("perf_rst_fetch", perf_fetch_cnt_out, 32'h0);
        reset  = 1'b0;
        ack_en = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            push(32'(i * 4));
            tick();
        end
        ack_en   = 1'b0;
        stall_in = 1'b1;
        repeat (4) tick();
        stall_in = 1'b0;
        chk("perf_fetch", perf_fetch_cnt_out, 32'd10);
        chk("perf_stall", perf_stall_cnt_out, 32'd4);
`endif

        tick();
        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d unconsumed entries, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
